// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control/datapath bundle between the multicycle control FSM and the shared-memory datapath
// master: control unit (drives enables, mux selects, state, fault, instr_count; reads opcode, zero, mem_ready)
// slave:  datapath side (drives opcode, zero, mem_ready; reads everything else)
interface multicycle_control_unit_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 16
);
    logic [OP_W-1:0]  opcode;
    logic             zero;
    logic             mem_ready;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             fault;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, fault, state, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, fault, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS control FSM with memory-ready stalls, timeout/illegal-opcode fault and retire counter
// clk, rst    : rising-edge clock, synchronous active-high reset
// bus.master  : opcode/zero/mem_ready in; datapath enables, mux selects, fault, state, instr_count out
// MCU_JUMP_EN : when defined, OP_J decodes to the JUMP state; otherwise OP_J is an illegal opcode
module multicycle_control_unit #(
    parameter int              OP_W        = 6,
    parameter logic [OP_W-1:0] OP_RTYPE    = 'h00,
    parameter logic [OP_W-1:0] OP_LW       = 'h23,
    parameter logic [OP_W-1:0] OP_SW       = 'h2B,
    parameter logic [OP_W-1:0] OP_BEQ      = 'h04,
    parameter logic [OP_W-1:0] OP_ADDI     = 'h08,
    parameter logic [OP_W-1:0] OP_J        = 'h02,
    parameter int              MEM_TIMEOUT = 15,
    parameter int              CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_unit_if.master bus
);
`ifdef MCU_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif
    localparam int WAIT_W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        FAULT  = 4'd15
    } state_t;

    state_t             state_q, next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instr_count_q;
    logic               fault_q;
    logic               timeout, mem_wait;
    logic               mem_read_c, mem_write_c, ir_write_c, reg_write_c, pc_write, pc_write_cond;

    assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign mem_wait = !bus.mem_ready && (state_q == FETCH || state_q == MEMRD || state_q == MEMWR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            wait_cnt      <= '0;
            instr_count_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= next_state;
            fault_q       <= fault_q | (next_state == FAULT);
            wait_cnt      <= next_state != state_q ? '0 : wait_cnt + WAIT_W'(mem_wait);
            // Only retiring states ever transition into FETCH
            if (next_state == FETCH && state_q != FETCH)
                instr_count_q <= instr_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state    = state_q;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        bus.iord      = 1'b0;
        bus.reg_dst   = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 2'b00;
        bus.pc_src    = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read_c    = 1'b1;
                bus.alu_src_b = 2'b01;
                ir_write_c    = bus.mem_ready;
                pc_write      = bus.mem_ready;
                next_state    = bus.mem_ready ? DECODE : timeout ? FAULT : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                if (bus.opcode == OP_RTYPE)                          next_state = EXEC;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW) next_state = MEMADR;
                else if (bus.opcode == OP_BEQ)                       next_state = BRANCH;
                else if (bus.opcode == OP_ADDI)                      next_state = ADDIEX;
                else if (JUMP_EN && bus.opcode == OP_J)              next_state = JUMP;
                else                                                 next_state = FAULT;
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                next_state    = bus.opcode == OP_LW ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.iord   = 1'b1;
                mem_read_c = 1'b1;
                next_state = bus.mem_ready ? MEMWB : timeout ? FAULT : MEMRD;
            end
            MEMWB: begin
                reg_write_c    = 1'b1;
                bus.mem_to_reg = 1'b1;
                next_state     = FETCH;
            end
            MEMWR: begin
                bus.iord    = 1'b1;
                mem_write_c = 1'b1;
                next_state  = bus.mem_ready ? FETCH : timeout ? FAULT : MEMWR;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                next_state    = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                bus.reg_dst = 1'b1;
                next_state  = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                pc_write_cond = 1'b1;
                next_state    = FETCH;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                next_state    = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                next_state  = FETCH;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            FAULT:   next_state = FAULT;
            default: next_state = FAULT;
        endcase
    end

    // Enables are forced low while reset is asserted, whatever the current state
    assign bus.mem_read    = mem_read_c & ~rst;
    assign bus.mem_write   = mem_write_c & ~rst;
    assign bus.ir_write    = ir_write_c & ~rst;
    assign bus.reg_write   = reg_write_c & ~rst;
    assign bus.pc_en       = (pc_write | (pc_write_cond & bus.zero)) & ~rst;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed self-checking bench for multicycle_control_unit (MEM_TIMEOUT=4)
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control_unit_if #(.OP_W(6), .CNT_W(16)) bus ();

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if ({bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write, bus.pc_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_gating enables=%b exp=00000", {bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write, bus.pc_en});
        end
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.state, bus.mem_read, bus.alu_src_b, bus.pc_en, bus.fault, bus.ir_write} !== {4'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state state=%0d mem_read=%b src_b=%b pc_en=%b fault=%b ir_write=%b", bus.state, bus.mem_read, bus.alu_src_b, bus.pc_en, bus.fault, bus.ir_write);
        end
        n_checks++;
        if (bus.instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d exp=0", bus.instr_count);
        end
        tick();
    endtask

    task automatic test_rtype();
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.state, bus.ir_write, bus.pc_en, bus.pc_src} !== {4'd0, 1'b1, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL rtype_fetch state=%0d ir_write=%b pc_en=%b pc_src=%b", bus.state, bus.ir_write, bus.pc_en, bus.pc_src);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.alu_src_b} !== {4'd1, 2'b11}) begin
            n_fail++;
            $display("FAIL rtype_decode state=%0d src_b=%b exp 1/11", bus.state, bus.alu_src_b);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {4'd6, 1'b1, 2'b00, 2'b10}) begin
            n_fail++;
            $display("FAIL rtype_exec state=%0d src_a=%b src_b=%b alu_op=%b", bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rtype_aluwb state=%0d reg_write=%b reg_dst=%b mem_to_reg=%b", bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL rtype_retire state=%0d count=%0d exp 0/1", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_lw_stall();
        bus.opcode = 6'h23;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b} !== {4'd2, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL lw_memadr state=%0d src_a=%b src_b=%b", bus.state, bus.alu_src_a, bus.alu_src_b);
        end
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({bus.state, bus.iord, bus.mem_read, bus.reg_write} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL lw_memrd_wait%0d state=%0d iord=%b mem_read=%b", i, bus.state, bus.iord, bus.mem_read);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.state !== 4'd3) begin
            n_fail++;
            $display("FAIL lw_memrd_last state=%0d exp=3", bus.state);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_memwb state=%0d reg_write=%b mem_to_reg=%b reg_dst=%b", bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd2}) begin
            n_fail++;
            $display("FAIL lw_retire state=%0d count=%0d exp 0/2", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_beq();
        bus.opcode = 6'h04;
        bus.mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            tick();
            tick();
            n_checks++;
            if ({bus.state, bus.pc_en, bus.pc_src, bus.alu_op, bus.alu_src_a} !== {4'd8, z[0], 2'b01, 2'b01, 1'b1}) begin
                n_fail++;
                $display("FAIL beq_zero%0d state=%0d pc_en=%b pc_src=%b alu_op=%b src_a=%b", z, bus.state, bus.pc_en, bus.pc_src, bus.alu_op, bus.alu_src_a);
            end
            tick();
        end
        bus.zero = 1'b0;
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd4}) begin
            n_fail++;
            $display("FAIL beq_retire state=%0d count=%0d exp 0/4", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_sw();
        bus.opcode = 6'h2B;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.state, bus.iord, bus.mem_write, bus.mem_read} !== {4'd5, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_memwr state=%0d iord=%b mem_write=%b mem_read=%b", bus.state, bus.iord, bus.mem_write, bus.mem_read);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd5}) begin
            n_fail++;
            $display("FAIL sw_retire state=%0d count=%0d exp 0/5", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_addi();
        bus.opcode = 6'h08;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {4'd9, 1'b1, 2'b10, 2'b00}) begin
            n_fail++;
            $display("FAIL addi_ex state=%0d src_a=%b src_b=%b alu_op=%b", bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_wb state=%0d reg_write=%b reg_dst=%b mem_to_reg=%b", bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd6}) begin
            n_fail++;
            $display("FAIL addi_retire state=%0d count=%0d exp 0/6", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_jump();
        bus.opcode = 6'h02;
        bus.mem_ready = 1'b1;
        tick();
        tick();
`ifdef MCU_JUMP_EN
        n_checks++;
        if ({bus.state, bus.pc_en, bus.pc_src, bus.fault} !== {4'd11, 1'b1, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_state state=%0d pc_en=%b pc_src=%b fault=%b", bus.state, bus.pc_en, bus.pc_src, bus.fault);
        end
        tick();
        n_checks++;
        if ({bus.state, bus.instr_count} !== {4'd0, 16'd7}) begin
            n_fail++;
            $display("FAIL jump_retire state=%0d count=%0d exp 0/7", bus.state, bus.instr_count);
        end
`else
        n_checks++;
        if ({bus.state, bus.fault, bus.pc_en, bus.pc_src} !== {4'd15, 1'b1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL jump_illegal state=%0d fault=%b pc_en=%b pc_src=%b", bus.state, bus.fault, bus.pc_en, bus.pc_src);
        end
        do_reset();
`endif
    endtask

    task automatic test_illegal();
        bus.opcode = 6'h3F;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.state, bus.fault, bus.mem_read, bus.ir_write, bus.reg_write, bus.pc_en} !== {4'd15, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL illegal_fault state=%0d fault=%b mem_read=%b ir_write=%b reg_write=%b pc_en=%b", bus.state, bus.fault, bus.mem_read, bus.ir_write, bus.reg_write, bus.pc_en);
        end
        do_reset();
        n_checks++;
        if ({bus.state, bus.fault, bus.instr_count} !== {4'd0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL illegal_reset state=%0d fault=%b count=%0d", bus.state, bus.fault, bus.instr_count);
        end
    endtask

    task automatic test_timeout();
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.state, bus.fault} !== {4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL ready_wins state=%0d fault=%b exp 1/0", bus.state, bus.fault);
        end
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({bus.state, bus.fault} !== {4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_wait%0d state=%0d fault=%b exp 0/0", i, bus.state, bus.fault);
            end
            tick();
        end
        n_checks++;
        if ({bus.state, bus.fault} !== {4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_fault state=%0d fault=%b exp 15/1", bus.state, bus.fault);
        end
        bus.mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.state, bus.fault, bus.mem_read} !== {4'd15, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_sticky state=%0d fault=%b mem_read=%b", bus.state, bus.fault, bus.mem_read);
        end
        do_reset();
        n_checks++;
        if ({bus.state, bus.fault} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_reset state=%0d fault=%b exp 0/0", bus.state, bus.fault);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_sw();
        test_addi();
        test_jump();
        test_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
